// File: rtl/mem_stage_vlsu_if.sv
// Pipeline command/response and RAM beat signals of the vector load/store unit.
// The slave modport is the unit itself; the master modport is the pipeline plus the RAM.
interface mem_stage_vlsu_if #(
  parameter int VEC_W  = 192,
  parameter int WORD_W = 32,
  parameter int ADDR_W = 16
);
  logic              mem_read_in;
  logic              mem_write_in;
  logic [ADDR_W-1:0] addr_in;
  logic [VEC_W-1:0]  wdata_in;
  logic              stall_out;
  logic              done_out;
  logic [VEC_W-1:0]  ld_data_out;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [WORD_W-1:0] ram_wdata;
  logic [WORD_W-1:0] ram_rdata;

  modport slave (
    input  mem_read_in, mem_write_in, addr_in, wdata_in, ram_rdata,
    output stall_out, done_out, ld_data_out, ram_addr, ram_we, ram_wdata
  );

  modport master (
    output mem_read_in, mem_write_in, addr_in, wdata_in, ram_rdata,
    input  stall_out, done_out, ld_data_out, ram_addr, ram_we, ram_wdata
  );
endinterface

// File: rtl/mem_stage_vlsu.sv
// Moves one VEC_W vector to/from a WORD_W synchronous RAM, one word per cycle; stores take
// BEATS+1 cycles to done, loads BEATS+1+RD_LAT. stall_out holds the pipeline until the done cycle.
module mem_stage_vlsu #(
  parameter int VEC_W  = 192,
  parameter int WORD_W = 32,
  parameter int ADDR_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  mem_stage_vlsu_if.slave bus
);
  localparam int BEATS = VEC_W / WORD_W;
  localparam int CNT_W = $clog2(BEATS + 1);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] RD_ISSUE = 3'd1;
  localparam logic [2:0] RD_DRAIN = 3'd2;
  localparam logic [2:0] WR_ISSUE = 3'd3;
  localparam logic [2:0] DONE     = 3'd4;

  logic [2:0]        state;
  logic [ADDR_W-1:0] base_q;
  logic [VEC_W-1:0]  wdata_q;
  logic [VEC_W-1:0]  asm_q;
  logic [VEC_W-1:0]  asm_next;
  logic [VEC_W-1:0]  ld_q;
  logic [CNT_W-1:0]  issue_cnt;
  logic [CNT_W-1:0]  cap_cnt;
  logic [RD_LAT-1:0] rd_pipe;
  logic [ADDR_W-1:0] ram_addr_q;
  logic              ram_we_q;
  logic [WORD_W-1:0] ram_wdata_q;
  logic [ADDR_W-1:0] issue_addr;
  logic              issuing;
  logic              cap;

  assign issuing    = (state == RD_ISSUE);
  assign cap        = rd_pipe[RD_LAT-1];
  assign issue_addr = base_q + ADDR_W'(issue_cnt);

  // The final lane lands on the same edge that publishes the vector, so publish the merged value.
  always_comb begin
    asm_next = asm_q;
    if (cap) asm_next[int'(cap_cnt)*WORD_W +: WORD_W] = bus.ram_rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      base_q      <= '0;
      wdata_q     <= '0;
      asm_q       <= '0;
      ld_q        <= '0;
      issue_cnt   <= '0;
      cap_cnt     <= '0;
      rd_pipe     <= '0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
    end else begin
      rd_pipe[0] <= issuing;
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
      if (cap) begin
        asm_q   <= asm_next;
        cap_cnt <= cap_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          if (bus.mem_write_in || bus.mem_read_in) begin
            base_q     <= bus.addr_in;
            wdata_q    <= bus.wdata_in;
            ram_addr_q <= bus.addr_in;
            issue_cnt  <= CNT_W'(1);
            cap_cnt    <= '0;
          end
          // Store wins when both commands are presented together.
          if (bus.mem_write_in) begin
            state       <= WR_ISSUE;
            ram_we_q    <= 1'b1;
            ram_wdata_q <= bus.wdata_in[WORD_W-1:0];
          end else if (bus.mem_read_in) begin
            state <= RD_ISSUE;
          end
        end

        WR_ISSUE: begin
          if (issue_cnt == CNT_W'(BEATS)) begin
            ram_we_q <= 1'b0;
            state    <= DONE;
          end else begin
            ram_addr_q  <= issue_addr;
            ram_wdata_q <= wdata_q[int'(issue_cnt)*WORD_W +: WORD_W];
            issue_cnt   <= issue_cnt + 1'b1;
          end
        end

        RD_ISSUE: begin
          if (issue_cnt == CNT_W'(BEATS)) begin
            state <= RD_DRAIN;
          end else begin
            ram_addr_q <= issue_addr;
            issue_cnt  <= issue_cnt + 1'b1;
          end
        end

        RD_DRAIN: begin
          if (cap && (cap_cnt == CNT_W'(BEATS - 1))) begin
            ld_q  <= asm_next;
            state <= DONE;
          end
        end

        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.stall_out   = ~rst & ((state == IDLE) ? (bus.mem_read_in | bus.mem_write_in)
                                                   : (state != DONE));
  assign bus.done_out    = (state == DONE);
  assign bus.ld_data_out = ld_q;
  assign bus.ram_addr    = ram_addr_q;
  assign bus.ram_we      = ram_we_q;
  assign bus.ram_wdata   = ram_wdata_q;
endmodule

// File: tb/tb_mem_stage_vlsu.sv
// Bench for mem_stage_vlsu: one unit at RD_LAT=1 and one at RD_LAT=2 sharing a RAM model.
module tb_mem_stage_vlsu;
  localparam int VEC_W = 192, WORD_W = 32, ADDR_W = 16;

  localparam logic [191:0] V1 = 192'h66666666_55555555_44444444_33333333_22222222_11111111;
  localparam logic [191:0] V2 = 192'hDEADBEEF_0BADF00D_CAFEBABE_12345678_9ABCDEF0_A5A5A5A5;
  localparam logic [191:0] V3 = 192'h0F0F0F0F_F0F0F0F0_13579BDF_2468ACE0_FEDCBA98_76543210;
  localparam logic [191:0] V4 = 192'hAAAA0005_AAAA0004_AAAA0003_AAAA0002_AAAA0001_AAAA0000;
  localparam logic [191:0] V5 = 192'h55550005_55550004_55550003_55550002_55550001_55550000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct { int cyc; logic [15:0] addr; logic [31:0] dat; } wr_t;
  typedef struct { int sel; int cyc; logic [191:0] ld; } dn_t;
  wr_t wr_q[$];
  dn_t dn_q[$];
  logic [191:0] ld_model [2];

  mem_stage_vlsu_if #(.VEC_W(VEC_W), .WORD_W(WORD_W), .ADDR_W(ADDR_W)) bus1 ();
  mem_stage_vlsu_if #(.VEC_W(VEC_W), .WORD_W(WORD_W), .ADDR_W(ADDR_W)) bus2 ();

  mem_stage_vlsu #(.VEC_W(VEC_W), .WORD_W(WORD_W), .ADDR_W(ADDR_W), .RD_LAT(1))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));
  mem_stage_vlsu #(.VEC_W(VEC_W), .WORD_W(WORD_W), .ADDR_W(ADDR_W), .RD_LAT(2))
    dut2 (.clk(clk), .rst(rst), .bus(bus2));

  // Shared RAM: dut1 writes and reads with latency 1, dut2 reads with latency 2.
  logic [31:0] mem [0:65535];
  logic [31:0] rd1, rd2a, rd2b;
  always @(posedge clk) begin
    if (bus1.ram_we) mem[bus1.ram_addr] <= bus1.ram_wdata;
    rd1  <= mem[bus1.ram_addr];
    rd2a <= mem[bus2.ram_addr];
    rd2b <= rd2a;
  end
  assign bus1.ram_rdata = rd1;
  assign bus2.ram_rdata = rd2b;

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_ev(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: event at cycle %0d, none expected", nm, cyc);
  endtask

  function automatic logic [31:0] lane(input logic [191:0] v, input int k);
    return v[k*32 +: 32];
  endfunction

  function automatic logic get_stall(input int sel);
    return sel == 1 ? bus2.stall_out : bus1.stall_out;
  endfunction

  function automatic logic [191:0] get_ld(input int sel);
    return sel == 1 ? bus2.ld_data_out : bus1.ld_data_out;
  endfunction

  task automatic drive(input int sel, input bit rd, input bit wr,
                       input logic [15:0] a, input logic [191:0] d);
    if (sel == 1) begin
      bus2.mem_read_in = rd; bus2.mem_write_in = wr; bus2.addr_in = a; bus2.wdata_in = d;
    end else begin
      bus1.mem_read_in = rd; bus1.mem_write_in = wr; bus1.addr_in = a; bus1.wdata_in = d;
    end
  endtask

  task automatic clear_cmds();
    drive(0, 1'b0, 1'b0, 16'h0, '0);
    drive(1, 1'b0, 1'b0, 16'h0, '0);
  endtask

  task automatic push_writes(input int t0, input logic [15:0] a, input logic [191:0] d, input int n);
    for (int k = 0; k < n; k++) wr_q.push_back('{t0 + 1 + k, a + 16'(k), lane(d, k)});
  endtask

  // Issue one command, queue its expected beats and done pulse, and watch stall/ld_data_out.
  task automatic run_cmd(input int sel, input bit rd, input bit wr, input logic [15:0] a,
                         input logic [191:0] d, input logic [191:0] exp_ld, input int lat);
    int t0, dur;
    logic [191:0] exp_done;
    dur = wr ? 7 : 7 + lat;
    @(posedge clk); #1;
    drive(sel, rd, wr, a, d);
    t0 = cyc;
    if (wr) push_writes(t0, a, d, 6);
    exp_done = (rd && !wr) ? exp_ld : ld_model[sel];
    dn_q.push_back('{sel, t0 + dur, exp_done});
    for (int c = 0; c <= dur; c++) begin
      @(negedge clk);
      chk($sformatf("stall_c%0d", c), get_stall(sel), (c < dur));
      if (c < dur) chk($sformatf("ld_hold_c%0d", c), get_ld(sel), ld_model[sel]);
      @(posedge clk); #1;
      if (c == 0) clear_cmds();
    end
    ld_model[sel] = exp_done;
  endtask

  // Scoreboard monitor: every write beat and done pulse must match the head of its queue.
  always @(negedge clk) begin : monitor
    wr_t e;
    dn_t d;
    if (bus1.ram_we) begin
      if (wr_q.size() == 0) fail_ev("wr_unexpected");
      else begin
        e = wr_q.pop_front();
        chk("wr_cycle", 192'(cyc), 192'(e.cyc));
        chk("wr_addr", 192'(bus1.ram_addr), 192'(e.addr));
        chk("wr_data", 192'(bus1.ram_wdata), 192'(e.dat));
      end
    end
    if (bus2.ram_we) fail_ev("wr_unexpected_dut2");
    for (int s = 0; s < 2; s++) begin
      if ((s == 0 && bus1.done_out) || (s == 1 && bus2.done_out)) begin
        if (dn_q.size() == 0) fail_ev($sformatf("done_unexpected_dut%0d", s + 1));
        else begin
          d = dn_q.pop_front();
          chk("done_unit", 192'(s), 192'(d.sel));
          chk("done_cycle", 192'(cyc), 192'(d.cyc));
          chk("done_ld_data", get_ld(s), d.ld);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin : stim
    int t0, t1;
    rst = 1'b1;
    clear_cmds();
    ld_model[0] = '0;
    ld_model[1] = '0;
    #2;
    chk("rst_stall", 192'(bus1.stall_out), 192'(0));
    chk("rst_done", 192'(bus1.done_out), 192'(0));
    chk("rst_we", 192'(bus1.ram_we), 192'(0));
    chk("rst_addr", 192'(bus1.ram_addr), 192'(0));
    chk("rst_wdata", 192'(bus1.ram_wdata), 192'(0));
    chk("rst_ld", bus1.ld_data_out, 192'(0));
    chk("rst_ld_dut2", bus2.ld_data_out, 192'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    run_cmd(0, 1'b0, 1'b1, 16'h0010, V1, '0, 1);     // store
    run_cmd(0, 1'b1, 1'b0, 16'h0010, '0, V1, 1);     // load, RD_LAT=1
    run_cmd(1, 1'b1, 1'b0, 16'h0010, '0, V1, 2);     // load, RD_LAT=2
    run_cmd(0, 1'b0, 1'b1, 16'hFFFE, V2, '0, 1);     // wrapping store
    run_cmd(0, 1'b1, 1'b0, 16'hFFFE, '0, V2, 1);     // wrapping load
    run_cmd(0, 1'b1, 1'b1, 16'h0020, V3, V3, 1);     // both: store only
    run_cmd(0, 1'b1, 1'b0, 16'h0020, '0, V3, 1);     // read back store-wins data

    // Back-to-back: store presented during the load's DONE cycle must wait one cycle.
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b0, 16'h0010, '0);
    t0 = cyc;
    dn_q.push_back('{0, t0 + 8, V1});
    @(posedge clk); #1;
    clear_cmds();
    repeat (7) @(posedge clk);
    #1;
    drive(0, 1'b0, 1'b1, 16'h0040, V5);
    @(negedge clk);
    chk("b2b_stall_in_done", 192'(bus1.stall_out), 192'(0));
    @(posedge clk); #1;
    t1 = cyc;
    push_writes(t1, 16'h0040, V5, 6);
    dn_q.push_back('{0, t1 + 7, V1});
    ld_model[0] = V1;
    @(negedge clk);
    chk("b2b_stall_accept", 192'(bus1.stall_out), 192'(1));
    @(posedge clk); #1;
    clear_cmds();
    repeat (8) @(posedge clk);
    #1;

    // Reset in cycle 3 of a store: only beats 0 and 1 reach the RAM, no done pulse.
    drive(0, 1'b0, 1'b1, 16'h0080, V4);
    t0 = cyc;
    push_writes(t0, 16'h0080, V4, 2);
    @(posedge clk); #1;
    clear_cmds();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_we", 192'(bus1.ram_we), 192'(0));
    chk("midrst_stall", 192'(bus1.stall_out), 192'(0));
    chk("midrst_done", 192'(bus1.done_out), 192'(0));
    chk("midrst_addr", 192'(bus1.ram_addr), 192'(0));
    chk("midrst_ld", bus1.ld_data_out, 192'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("post_rst_idle_stall", 192'(bus1.stall_out), 192'(0));
    chk("ram_beat0_kept", 192'(mem[16'h0080]), 192'(lane(V4, 0)));
    chk("ram_beat1_kept", 192'(mem[16'h0081]), 192'(lane(V4, 1)));
    chk("wr_q_drained", 192'(wr_q.size()), 192'(0));
    chk("done_q_drained", 192'(dn_q.size()), 192'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
